fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO. Runs entirely in the read clock domain and drives the dual-clock memory's read port (raddr, rd_en).
- Synchronizes the write pointer (Gray) into clk_rd and computes empty.
- Issues memory reads and absorbs the memory's 1-cycle registered read latency in a 2-entry output buffer.
- Presents a first-word-fall-through valid/ready interface to the consumer, and exports its Gray read pointer to the write domain.

---
 rtl/fifo_rd_ctrl.sv | 149 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO (clk_rd domain).
// Synchronizes the Gray write pointer, derives empty/rd_count, issues
// memory reads and turns the 1-cycle registered memory latency into a
// first-word-fall-through valid/ready stream.
// Handshake: a word transfers on a clk_rd edge where data_valid & data_ready;
// data_out/data_valid never depend on data_ready, and data_out holds while
// data_valid & !data_ready.
// Optional: define FIFO_RD_ALMOST_EMPTY_EN to add the registered
// almost_empty output (rd_count <= AE_LEVEL).
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                  clk_rd,
    input  logic                  rst_rd,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic                  almost_empty
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         sync_q [SYNC_STAGES];
    logic [PW-1:0]         sync_d [SYNC_STAGES];
    logic [PW-1:0]         wsync;
    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rptr_bin_q, rptr_bin_d;
    logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  pop;
    logic                  pop_buf;
    logic [2:0]            level;
    logic [1:0]            widx;

    // Write-pointer synchronizer chain: stage 0 samples the async input.
    always_comb begin
        sync_d[0] = wptr_gray_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchronizer registers.
    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    assign wsync = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wsync >> i);
        end
    end

    // Status, read issue and return-path bookkeeping.
    // The word returning on mem_rdata (inflight) bypasses straight to
    // data_out when the buffer is empty, so data_valid rises one cycle after
    // the issue. occ counts only stored words; occ + inflight never exceeds 2
    // because an issue is only allowed while that sum (after pop) is below 2.
    always_comb begin
        empty      = (rptr_gray_q == wsync);
        rd_count   = wbin - rptr_bin_q;
        data_valid = (occ_q != 2'd0) | inflight_q;
        data_out   = (occ_q == 2'd0 && inflight_q) ? mem_rdata : buf_q[0];
        pop        = data_valid & data_ready;
        level      = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        mem_rd_en  = !empty && (level < 3'd2);
        raddr      = rptr_bin_q[ADDR_WIDTH-1:0];
        rptr_gray  = rptr_gray_q;

        rptr_bin_d  = rptr_bin_q + PW'(mem_rd_en);
        rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
        inflight_d  = mem_rd_en;
        occ_d       = level[1:0];

        // Pop from the stored buffer (shift head) unless the popped word is
        // the bypassed in-flight one.
        pop_buf  = pop && (occ_q != 2'd0);
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        if (pop_buf) begin
            buf_d[0] = buf_q[1];
        end
        widx = occ_q - {1'b0, pop_buf};
        if (inflight_q && !(pop && occ_q == 2'd0)) begin
            buf_d[widx[0]] = mem_rdata;
        end
    end

    // Read pointer, in-flight flag and output buffer registers.
    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf_q[0]    <= buf_d[0];
            buf_q[1]    <= buf_d[1];
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic ae_q, ae_d;

    // Almost-empty threshold compare, registered.
    always_comb begin
        ae_d = (rd_count <= PW'(AE_LEVEL));
    end

    // Almost-empty register; reset reports almost empty.
    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) ae_q <= 1'b1;
        else        ae_q <= ae_d;
    end

    assign almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int SYNC = 2;
  localparam int AE = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PMASK = (1 << (AW + 1)) - 1;

  logic          clk_rd = 1'b0;
  logic          rst_rd = 1'b1;
  logic [AW:0]   wptr_gray_async = '0;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] raddr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          empty;
  logic [AW:0]   rd_count;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AE_LEVEL(AE)) dut (
    .clk_rd(clk_rd),
    .rst_rd(rst_rd),
    .wptr_gray_async(wptr_gray_async),
    .rptr_gray(rptr_gray),
    .raddr(raddr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .empty(empty),
    .rd_count(rd_count)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .almost_empty(almost_empty)
`endif
  );

  // clock / reset block
  always #5 clk_rd = ~clk_rd;

  // dual-clock memory model: registered read port
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk_rd) if (mem_rd_en) mem_rdata <= mem[raddr];

  // reference model state (word counts, not pointers)
  logic [DW-1:0] exp_q[$];    // words written, not yet consumed, in order
  logic [DW-1:0] wdata_q[$];  // directed data for the next writes
  int            hist_q[$];   // write count seen at recent clk_rd edges
  int            wr_cnt, issued, popped;
  int            exp_rdc;
  bit            exp_en, exp_pop, exp_ae;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int visible_cnt();
    return (hist_q.size() == SYNC) ? hist_q[0] : 0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    hist_q.delete();
    wr_cnt = 0;
    issued = 0;
    popped = 0;
    exp_ae = 1'b1;
  endtask

  // one clk_rd cycle: drive at negedge, check, then advance the model
  task automatic step(input bit rdy, input int nwr);
    logic [DW-1:0] d;
    bit dv;
    @(negedge clk_rd);
    for (int k = 0; k < nwr; k++) begin
      if (wr_cnt - popped < DEPTH) begin
        d = (wdata_q.size() != 0) ? wdata_q.pop_front() : DW'($urandom);
        mem[wr_cnt % DEPTH] = d;
        exp_q.push_back(d);
        wr_cnt++;
      end
    end
    wptr_gray_async = to_gray(wr_cnt);
    data_ready = rdy;
    #1;
    exp_rdc = (visible_cnt() - issued) & PMASK;
    dv = (issued > popped);
    exp_pop = dv && rdy;
    exp_en = (exp_rdc != 0) && ((issued - popped - int'(exp_pop)) < 2);
    check_eq("rd_count", rd_count, exp_rdc);
    check_eq("empty", empty, exp_rdc == 0);
    check_eq("rptr_gray", rptr_gray, to_gray(issued));
    check_eq("raddr", raddr, issued % DEPTH);
    check_eq("data_valid", data_valid, dv);
    if (dv) check_eq("data_out", data_out, exp_q[0]);
    check_eq("mem_rd_en", mem_rd_en, exp_en);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check_eq("almost_empty", almost_empty, exp_ae);
`endif
    @(posedge clk_rd);
    if (exp_en) issued++;
    if (exp_pop) begin
      void'(exp_q.pop_front());
      popped++;
    end
    hist_q.push_back(wr_cnt);
    if (hist_q.size() > SYNC) void'(hist_q.pop_front());
    exp_ae = (exp_rdc <= AE);
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic mid_reset();
    @(negedge clk_rd);
    #2 rst_rd = 1'b1;
    #1;
    check_eq("rst data_valid", data_valid, 0);
    check_eq("rst empty", empty, 1);
    check_eq("rst rptr_gray", rptr_gray, 0);
    check_eq("rst mem_rd_en", mem_rd_en, 0);
    check_eq("rst rd_count", rd_count, 0);
    check_eq("rst data_out", data_out, 0);
    check_eq("rst raddr", raddr, 0);
    model_clear();
    wptr_gray_async = '0;
    data_ready = 1'b0;
    @(negedge clk_rd);
    @(negedge clk_rd);
    rst_rd = 1'b0;
  endtask

  initial begin
    model_clear();
    #3;
    mid_reset();

    // single word: issue after the synchronizer, visible one cycle later
    wdata_q.push_back(8'hA5);
    step(1'b1, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 0);

    // three words with consumer stalled, then drained back to back
    wdata_q.push_back(8'h11);
    wdata_q.push_back(8'h22);
    wdata_q.push_back(8'h33);
    step(1'b0, 3);
    for (int i = 0; i < 6; i++) step(1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 0);

    // full FIFO seen at once (rd_count = depth), drain, then wrap
    mid_reset();
    step(1'b0, DEPTH);
    for (int i = 0; i < 5; i++) step(1'b0, 0);
    for (int i = 0; i < DEPTH + 4; i++) step(1'b1, 0);
    step(1'b1, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 0);

    // reset with buffered and in-flight words; nothing stale afterwards
    step(1'b0, 4);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b0, 0);
    mid_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end
    for (int i = 0; i < 40; i++) step(1'b1, 0);
    check_eq("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
